alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 49 ++++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Signal bundle between two requesters, the round-robin arbiter and the shared ALU.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if #(
  parameter int unsigned OPW = 3
) ();
  logic           Req0Valid;
  logic           Req1Valid;
  logic [31:0]    Req0A;
  logic [31:0]    Req0B;
  logic [31:0]    Req1A;
  logic [31:0]    Req1B;
  logic [OPW-1:0] Req0Op;
  logic [OPW-1:0] Req1Op;
  logic           Req0Ready;
  logic           Req1Ready;
  logic [31:0]    AluA;
  logic [31:0]    AluB;
  logic [OPW-1:0] AluOp;
  logic [31:0]    AluResult;
  logic           AluZero;
  logic           Resp0Valid;
  logic           Resp1Valid;
  logic           Resp0Ready;
  logic           Resp1Ready;
  logic [31:0]    RespData;
  logic           RespZero;
  logic           Busy;
  logic [15:0]    OpCount;

  modport slave (
    input  Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B, Req0Op, Req1Op,
    output Req0Ready, Req1Ready,
    output AluA, AluB, AluOp,
    input  AluResult, AluZero,
    output Resp0Valid, Resp1Valid,
    input  Resp0Ready, Resp1Ready,
    output RespData, RespZero, Busy, OpCount
  );

  modport master (
    output Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B, Req0Op, Req1Op,
    input  Req0Ready, Req1Ready,
    input  AluA, AluB, AluOp,
    output AluResult, AluZero,
    input  Resp0Valid, Resp1Valid,
    output Resp0Ready, Resp1Ready,
    input  RespData, RespZero, Busy, OpCount
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter for a shared ALU: accept, wait LAT settle
// cycles, then hold the registered result until the owner takes it.
module alu_arbiter #(
  parameter int unsigned LAT = 1,
  parameter int unsigned OPW = 3
) (
  input  logic         CLK,
  input  logic         RST,
  alu_arbiter_if.slave bus
);
  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] LatCnt = CntW'(LAT);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [31:0]     data_q, data_d;
  logic            zero_q, zero_d;
  logic [15:0]     count_q, count_d;

  logic grant0, grant1, accept0, accept1, resp_hs;

  // On a tie the requester that was not granted last wins.
  assign grant0 = bus.Req0Valid && (!bus.Req1Valid || last_grant_q);
  assign grant1 = bus.Req1Valid && (!bus.Req0Valid || !last_grant_q);

  // Gated by RST so Ready drops the moment reset asserts.
  assign bus.Req0Ready = RST && (state_q == StIdle) && grant0;
  assign bus.Req1Ready = RST && (state_q == StIdle) && grant1;

  assign accept0 = bus.Req0Valid && bus.Req0Ready;
  assign accept1 = bus.Req1Valid && bus.Req1Ready;

  assign bus.Resp0Valid = (state_q == StResp) && !owner_q;
  assign bus.Resp1Valid = (state_q == StResp) && owner_q;
  assign resp_hs = (bus.Resp0Valid && bus.Resp0Ready) || (bus.Resp1Valid && bus.Resp1Ready);

  assign bus.AluA     = a_q;
  assign bus.AluB     = b_q;
  assign bus.AluOp    = op_q;
  assign bus.RespData = data_q;
  assign bus.RespZero = zero_q;
  assign bus.Busy     = (state_q != StIdle);
  assign bus.OpCount  = count_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    data_d       = data_q;
    zero_d       = zero_q;
    count_d      = count_q;
    unique case (state_q)
      StIdle: begin
        if (accept0 || accept1) begin
          state_d      = StExec;
          owner_d      = accept1;
          last_grant_d = accept1;
          a_d          = accept1 ? bus.Req1A : bus.Req0A;
          b_d          = accept1 ? bus.Req1B : bus.Req0B;
          op_d         = accept1 ? bus.Req1Op : bus.Req0Op;
          cnt_d        = '0;
        end
      end
      StExec: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == LatCnt) begin
          data_d  = bus.AluResult;
          zero_d  = bus.AluZero;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_hs) begin
          state_d = StIdle;
          count_d = count_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      data_q       <= '0;
      zero_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      data_q       <= data_d;
      zero_q       <= zero_d;
      count_q      <= count_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter: LAT=1 and LAT=3 instances
// against a transaction-level model of grant order, latency, results and counts.
module tb_alu_arbiter;
  localparam int unsigned Lat1 = 1;
  localparam int unsigned Lat3 = 3;
  localparam int unsigned Opw  = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  alu_arbiter_if #(.OPW(Opw)) bus1 ();
  alu_arbiter_if #(.OPW(Opw)) bus3 ();

  alu_arbiter #(.LAT(Lat1), .OPW(Opw)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  alu_arbiter #(.LAT(Lat3), .OPW(Opw)) dut3 (.CLK(CLK), .RST(RST), .bus(bus3));

  int checks = 0;
  int errors = 0;

  // Reference model state: who was granted last and how many responses completed.
  bit          m_last;
  logic [15:0] m_count;
  logic [15:0] m3_count;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return {31'd0, ($signed(a) < $signed(b))};
      default: return b;
    endcase
  endfunction

  assign bus1.AluResult = alu_fn(bus1.AluA, bus1.AluB, bus1.AluOp);
  assign bus1.AluZero   = (alu_fn(bus1.AluA, bus1.AluB, bus1.AluOp) == 32'd0);
  assign bus3.AluResult = alu_fn(bus3.AluA, bus3.AluB, bus3.AluOp);
  assign bus3.AluZero   = (alu_fn(bus3.AluA, bus3.AluB, bus3.AluOp) == 32'd0);

  task automatic clear_inputs();
    bus1.Req0Valid = 0; bus1.Req1Valid = 0; bus1.Resp0Ready = 0; bus1.Resp1Ready = 0;
    bus1.Req0A = '0; bus1.Req0B = '0; bus1.Req0Op = '0;
    bus1.Req1A = '0; bus1.Req1B = '0; bus1.Req1Op = '0;
    bus3.Req0Valid = 0; bus3.Req1Valid = 0; bus3.Resp0Ready = 0; bus3.Resp1Ready = 0;
    bus3.Req0A = '0; bus3.Req0B = '0; bus3.Req0Op = '0;
    bus3.Req1A = '0; bus3.Req1B = '0; bus3.Req1Op = '0;
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic do_reset();
    #1 RST = 1'b0;
    clear_inputs();
    #2 RST = 1'b1;
    m_last   = 1'b1;
    m_count  = '0;
    m3_count = '0;
    @(posedge CLK); #1;
  endtask

  // One full transaction on the LAT=1 instance: grant, settle, optional backpressure, handshake.
  task automatic txn(input logic v0, input logic v1,
                     input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                     input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                     input int hold, input bit keep, output int g);
    logic [31:0] exp_d;
    logic [1:0]  exp_rdy, exp_rv;
    int n;
    bus1.Req0Valid = v0; bus1.Req0A = a0; bus1.Req0B = b0; bus1.Req0Op = op0;
    bus1.Req1Valid = v1; bus1.Req1A = a1; bus1.Req1B = b1; bus1.Req1Op = op1;
    #1;
    if (v0 && v1)  g = m_last ? 0 : 1;
    else if (v0)   g = 0;
    else if (v1)   g = 1;
    else           g = -1;
    exp_rdy = {g == 1, g == 0};
    checks++;
    if ({bus1.Req1Ready, bus1.Req0Ready} !== exp_rdy) begin
      errors++;
      $display("FAIL grant: ready=%b expected=%b", {bus1.Req1Ready, bus1.Req0Ready}, exp_rdy);
    end
    exp_d = (g == 1) ? alu_fn(a1, b1, op1) : alu_fn(a0, b0, op0);
    @(posedge CLK); #1;
    if (g < 0) begin
      checks++;
      if (bus1.Busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_accept: busy=%b expected=0", bus1.Busy);
      end
      return;
    end
    m_last = (g == 1);
    if (!keep) begin
      bus1.Req0Valid = 0;
      bus1.Req1Valid = 0;
    end
    bus1.Req0A = $urandom(); bus1.Req0B = $urandom(); bus1.Req0Op = 3'($urandom());
    bus1.Req1A = $urandom(); bus1.Req1B = $urandom(); bus1.Req1Op = 3'($urandom());
    n = 0;
    while (!(bus1.Resp0Valid || bus1.Resp1Valid) && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (n != Lat1) begin
      errors++;
      $display("FAIL latency: cycles=%0d expected=%0d", n, Lat1);
    end
    exp_rv = (g == 1) ? 2'b10 : 2'b01;
    checks++;
    if ({bus1.Resp1Valid, bus1.Resp0Valid} !== exp_rv) begin
      errors++;
      $display("FAIL resp_owner: valid=%b expected=%b", {bus1.Resp1Valid, bus1.Resp0Valid}, exp_rv);
    end
    checks++;
    if (bus1.RespData !== exp_d || bus1.RespZero !== (exp_d == 32'd0)) begin
      errors++;
      $display("FAIL resp_data: data=%h zero=%b expected data=%h zero=%b",
               bus1.RespData, bus1.RespZero, exp_d, exp_d == 32'd0);
    end
    checks++;
    if ({bus1.Busy, bus1.Req1Ready, bus1.Req0Ready} !== 3'b100) begin
      errors++;
      $display("FAIL busy_in_resp: busy/rdy1/rdy0=%b expected=100",
               {bus1.Busy, bus1.Req1Ready, bus1.Req0Ready});
    end
    for (int i = 0; i < hold; i++) begin
      // Non-owner Ready and fresh requests must both be ignored while the response is held.
      if (g == 1) bus1.Resp0Ready = 1; else bus1.Resp1Ready = 1;
      bus1.Req0Valid = 1;
      bus1.Req1Valid = 1;
      @(posedge CLK); #1;
      checks++;
      if ({bus1.Busy, bus1.Req1Ready, bus1.Req0Ready, bus1.Resp1Valid, bus1.Resp0Valid}
          !== {3'b100, exp_rv} || bus1.RespData !== exp_d) begin
        errors++;
        $display("FAIL backpressure: busy/rdy/rv=%b data=%h expected=%b data=%h",
                 {bus1.Busy, bus1.Req1Ready, bus1.Req0Ready, bus1.Resp1Valid, bus1.Resp0Valid},
                 bus1.RespData, {3'b100, exp_rv}, exp_d);
      end
    end
    bus1.Resp0Ready = 0;
    bus1.Resp1Ready = 0;
    bus1.Req0Valid  = keep ? v0 : 1'b0;
    bus1.Req1Valid  = keep ? v1 : 1'b0;
    if (g == 1) bus1.Resp1Ready = 1; else bus1.Resp0Ready = 1;
    @(posedge CLK); #1;
    bus1.Resp0Ready = 0;
    bus1.Resp1Ready = 0;
    m_count = m_count + 16'd1;
    checks++;
    if (bus1.OpCount !== m_count || {bus1.Busy, bus1.Resp1Valid, bus1.Resp0Valid} !== 3'b000) begin
      errors++;
      $display("FAIL handshake: count=%h busy/rv=%b expected count=%h busy/rv=000",
               bus1.OpCount, {bus1.Busy, bus1.Resp1Valid, bus1.Resp0Valid}, m_count);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    bus1.Req0Valid = 1; bus1.Req0A = 32'd5; bus1.Req0B = 32'd3; bus1.Req0Op = 3'd0;
    #1 RST = 1'b0;
    m_last = 1'b1; m_count = '0; m3_count = '0;
    #1;
    checks++;
    if ({bus1.Busy, bus1.Req1Ready, bus1.Req0Ready, bus1.Resp1Valid, bus1.Resp0Valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/rdy/rv=%b expected=00000",
               {bus1.Busy, bus1.Req1Ready, bus1.Req0Ready, bus1.Resp1Valid, bus1.Resp0Valid});
    end
    checks++;
    if (bus1.AluA !== 32'd0 || bus1.AluB !== 32'd0 || bus1.AluOp !== 3'd0 ||
        bus1.RespData !== 32'd0 || bus1.RespZero !== 1'b0 || bus1.OpCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs: a=%h b=%h op=%h data=%h zero=%b count=%h expected all zero",
               bus1.AluA, bus1.AluB, bus1.AluOp, bus1.RespData, bus1.RespZero, bus1.OpCount);
    end
    #10 RST = 1'b1;
    #1;
    checks++;
    if (bus1.Req0Ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: rdy0=%b expected=1", bus1.Req0Ready);
    end
    @(posedge CLK); #1;
    checks++;
    if (bus1.Busy !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_accept: busy=%b expected=1", bus1.Busy);
    end
    m_last = 1'b0;
    bus1.Req0Valid = 0;
    @(posedge CLK); #1;
    checks++;
    if (bus1.Resp0Valid !== 1'b1 || bus1.RespData !== 32'd8 || bus1.RespZero !== 1'b0) begin
      errors++;
      $display("FAIL single_add: rv0=%b data=%h zero=%b expected rv0=1 data=8 zero=0",
               bus1.Resp0Valid, bus1.RespData, bus1.RespZero);
    end
    bus1.Resp0Ready = 1;
    @(posedge CLK); #1;
    bus1.Resp0Ready = 0;
    m_count = m_count + 16'd1;
    checks++;
    if (bus1.OpCount !== 16'd1) begin
      errors++;
      $display("FAIL single_count: count=%h expected=0001", bus1.OpCount);
    end
  endtask

  task automatic test_tie_alternation();
    int g;
    do_reset();
    for (int i = 0; i < 4; i++)
      txn(1, 1, $urandom(), $urandom(), 3'($urandom()), $urandom(), $urandom(), 3'($urandom()),
          i % 2, 1'b1, g);
    bus1.Req0Valid = 0;
    bus1.Req1Valid = 0;
  endtask

  task automatic test_backpressure();
    int g;
    txn(1, 0, $urandom(), $urandom(), 3'($urandom()), 32'd0, 32'd0, 3'd0, 10, 1'b0, g);
  endtask

  task automatic test_drop_valid();
    int g;
    bus1.Req1Valid = 1;
    #1;
    checks++;
    if (bus1.Req1Ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready: rdy1=%b expected=1", bus1.Req1Ready);
    end
    #1 bus1.Req1Valid = 0;
    @(posedge CLK); #1;
    checks++;
    if (bus1.Busy !== 1'b0 || bus1.OpCount !== m_count) begin
      errors++;
      $display("FAIL drop_no_change: busy=%b count=%h expected busy=0 count=%h",
               bus1.Busy, bus1.OpCount, m_count);
    end
    txn(1, 1, $urandom(), $urandom(), 3'($urandom()), $urandom(), $urandom(), 3'($urandom()),
        0, 1'b0, g);
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 40; i++)
      txn(1'($urandom()), 1'($urandom()), $urandom(), $urandom_range(0, 40), 3'($urandom()),
          $urandom(), $urandom_range(0, 40), 3'($urandom()), $urandom_range(0, 3), 1'b0, g);
  endtask

  task automatic test_reset_exec();
    logic [31:0] exp_d;
    bus1.Req0Valid = 1; bus1.Req0A = $urandom(); bus1.Req0B = $urandom();
    bus1.Req0Op = 3'($urandom_range(1, 7));
    bus1.Req1Valid = 0;
    exp_d = alu_fn(bus1.Req0A, bus1.Req0B, bus1.Req0Op);
    @(posedge CLK); #1;
    checks++;
    if (bus1.Busy !== 1'b1) begin
      errors++;
      $display("FAIL exec_entry: busy=%b expected=1", bus1.Busy);
    end
    #1 RST = 1'b0;
    m_last = 1'b1; m_count = '0; m3_count = '0;
    #1;
    checks++;
    if ({bus1.Busy, bus1.Req1Ready, bus1.Req0Ready, bus1.Resp1Valid, bus1.Resp0Valid} !== 5'b0 ||
        bus1.OpCount !== 16'd0 || bus1.AluOp !== 3'd0 || bus1.AluA !== 32'd0) begin
      errors++;
      $display("FAIL exec_abort: busy/rdy/rv=%b count=%h op=%h a=%h expected all zero",
               {bus1.Busy, bus1.Req1Ready, bus1.Req0Ready, bus1.Resp1Valid, bus1.Resp0Valid},
               bus1.OpCount, bus1.AluOp, bus1.AluA);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      checks++;
      if ({bus1.Busy, bus1.Resp1Valid, bus1.Resp0Valid} !== 3'b000) begin
        errors++;
        $display("FAIL held_in_reset: busy/rv=%b expected=000",
                 {bus1.Busy, bus1.Resp1Valid, bus1.Resp0Valid});
      end
    end
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (bus1.Busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_accept: busy=%b expected=1", bus1.Busy);
    end
    m_last = 1'b0;
    bus1.Req0Valid = 0;
    @(posedge CLK); #1;
    checks++;
    if (bus1.Resp0Valid !== 1'b1 || bus1.RespData !== exp_d) begin
      errors++;
      $display("FAIL post_reset_resp: rv0=%b data=%h expected rv0=1 data=%h",
               bus1.Resp0Valid, bus1.RespData, exp_d);
    end
    bus1.Resp0Ready = 1;
    @(posedge CLK); #1;
    bus1.Resp0Ready = 0;
    m_count = m_count + 16'd1;
    checks++;
    if (bus1.OpCount !== m_count) begin
      errors++;
      $display("FAIL post_reset_count: count=%h expected=%h", bus1.OpCount, m_count);
    end
  endtask

  task automatic test_zero_lat3();
    int n;
    bus3.Req1Valid = 1; bus3.Req1A = 32'h1234; bus3.Req1B = 32'h1234; bus3.Req1Op = 3'b001;
    #1;
    checks++;
    if ({bus3.Req1Ready, bus3.Req0Ready} !== 2'b10) begin
      errors++;
      $display("FAIL lat3_grant: ready=%b expected=10", {bus3.Req1Ready, bus3.Req0Ready});
    end
    @(posedge CLK); #1;
    bus3.Req1Valid = 0;
    n = 0;
    while (!bus3.Resp1Valid && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (n != Lat3) begin
      errors++;
      $display("FAIL lat3_latency: cycles=%0d expected=%0d", n, Lat3);
    end
    checks++;
    if (bus3.RespData !== 32'd0 || bus3.RespZero !== 1'b1 || bus3.Resp0Valid !== 1'b0) begin
      errors++;
      $display("FAIL lat3_zero: data=%h zero=%b rv0=%b expected data=0 zero=1 rv0=0",
               bus3.RespData, bus3.RespZero, bus3.Resp0Valid);
    end
    bus3.Resp1Ready = 1;
    @(posedge CLK); #1;
    bus3.Resp1Ready = 0;
    m3_count = m3_count + 16'd1;
    checks++;
    if (bus3.OpCount !== m3_count || bus3.Busy !== 1'b0) begin
      errors++;
      $display("FAIL lat3_count: count=%h busy=%b expected count=%h busy=0",
               bus3.OpCount, bus3.Busy, m3_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus1.Req0Valid = 1; bus1.Req0A = 32'd1; bus1.Req0B = 32'd2; bus1.Req0Op = 3'd0;
    bus1.Resp0Ready = 1;
    // Each operation takes exactly accept, settle and handshake edges.
    repeat (3 * 65535) @(posedge CLK);
    #1;
    m_count = m_count + 16'hFFFF;
    checks++;
    if (bus1.OpCount !== m_count || bus1.Busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_preload: count=%h busy=%b expected count=%h busy=0",
               bus1.OpCount, bus1.Busy, m_count);
    end
    repeat (3) @(posedge CLK);
    #1;
    bus1.Req0Valid = 0;
    bus1.Resp0Ready = 0;
    m_count = m_count + 16'd1;
    checks++;
    if (bus1.OpCount !== m_count) begin
      errors++;
      $display("FAIL wrap: count=%h expected=%h", bus1.OpCount, m_count);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tie_alternation();
    test_backpressure();
    test_drop_valid();
    test_random();
    test_reset_exec();
    test_zero_lat3();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
